// File: rtl/keyboard_scancode_decoder.sv
// keyboard_scancode_decoder
// Receives PS/2 keyboard frames, checks framing/parity, strips break (F0) and
// extended (E0) sequences and maps accepted make codes to a 4-bit key code.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   kb_clk       PS/2 clock from keyboard (asynchronous)
//   kb_data      PS/2 data from keyboard (asynchronous)
//   binary_val   key code, held until the next accepted key
//   val_valid    one-cycle strobe, binary_val is new this cycle
//   frame_err    one-cycle strobe on a rejected frame or timeout
module keyboard_scancode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [3:0] binary_val,
  output logic       val_valid,
  output logic       frame_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BW = 4;
  localparam int unsigned FW = 10;

  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_CHECK, RX_ERR} rx_state_t;
  typedef enum logic [1:0] {P_MAKE, P_EXT, P_BREAK} p_state_t;

  rx_state_t      rx_state, rx_nxt;
  p_state_t       p_state, p_nxt;
  logic [2:0]     kc_sync;
  logic [1:0]     kd_sync;
  logic [BW-1:0]  bitcnt, bitcnt_nxt;
  logic [FW-1:0]  sr, sr_nxt;
  logic [TW-1:0]  tmo_cnt, tmo_nxt;
  logic [3:0]     bv_nxt;
  logic           vv_nxt, fe_nxt;
  logic           fall, din;
  logic           map_hit;
  logic [3:0]     map_val;
  logic           frame_ok;

  // Make code to key code lookup; bit 4 flags a mapped code.
  function automatic logic [4:0] map_code(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    case (b)
      8'h45: r = {1'b1, 4'd0};
      8'h16: r = {1'b1, 4'd1};
      8'h1E: r = {1'b1, 4'd2};
      8'h26: r = {1'b1, 4'd3};
      8'h25: r = {1'b1, 4'd4};
      8'h2E: r = {1'b1, 4'd5};
      8'h36: r = {1'b1, 4'd6};
      8'h3D: r = {1'b1, 4'd7};
      8'h3E: r = {1'b1, 4'd8};
      8'h46: r = {1'b1, 4'd9};
      8'h79: r = {1'b1, 4'd10};
      8'h7B: r = {1'b1, 4'd11};
      8'h7C: r = {1'b1, 4'd12};
      8'h4A: r = {1'b1, 4'd13};
      8'h66: r = {1'b1, 4'd14};
      8'h5A: r = {1'b1, 4'hF};
      8'h76: r = {1'b1, 4'hE};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // Two-flop synchronisers; third kb_clk stage for falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_sync <= 3'b111;
      kd_sync <= 2'b11;
    end else begin
      kc_sync <= {kc_sync[1:0], kb_clk};
      kd_sync <= {kd_sync[0], kb_data};
    end
  end

  assign fall = kc_sync[2] & ~kc_sync[1];
  assign din  = kd_sync[1];

  // Frame is {stop, parity, data[7:0]} after ten LSB-first shifts.
  assign frame_ok = (^sr[8:0]) & sr[9];

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      p_state    <= P_MAKE;
      bitcnt     <= '0;
      sr         <= '0;
      tmo_cnt    <= '0;
      binary_val <= 4'd0;
      val_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_nxt;
      p_state    <= p_nxt;
      bitcnt     <= bitcnt_nxt;
      sr         <= sr_nxt;
      tmo_cnt    <= tmo_nxt;
      binary_val <= bv_nxt;
      val_valid  <= vv_nxt;
      frame_err  <= fe_nxt;
    end
  end

  // Receiver and prefix next-state / next-output logic.
  always_comb begin
    rx_nxt     = rx_state;
    p_nxt      = p_state;
    bitcnt_nxt = bitcnt;
    sr_nxt     = sr;
    tmo_nxt    = tmo_cnt;
    bv_nxt     = binary_val;
    vv_nxt     = 1'b0;
    fe_nxt     = 1'b0;
    {map_hit, map_val} = map_code(sr[7:0]);

    case (rx_state)
      RX_IDLE: begin
        tmo_nxt = '0;
        if (fall) begin
          if (!din) begin
            rx_nxt     = RX_BITS;
            bitcnt_nxt = '0;
          end else begin
            // Delay the error one cycle so it lines up with frame-end timing.
            rx_nxt = RX_ERR;
          end
        end
      end

      RX_BITS: begin
        if (fall) begin
          sr_nxt     = {din, sr[FW-1:1]};
          bitcnt_nxt = BW'(bitcnt + BW'(1));
          tmo_nxt    = '0;
          if (bitcnt == BW'(FW - 1)) begin
            rx_nxt = RX_CHECK;
          end
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_nxt = '0;
          fe_nxt  = 1'b1;
          p_nxt   = P_MAKE;
          rx_nxt  = RX_IDLE;
        end else begin
          tmo_nxt = TW'(tmo_cnt + TW'(1));
        end
      end

      RX_CHECK: begin
        rx_nxt  = RX_IDLE;
        tmo_nxt = '0;
        if (!frame_ok) begin
          fe_nxt = 1'b1;
          p_nxt  = P_MAKE;
        end else begin
          case (p_state)
            P_MAKE: begin
              if (sr[7:0] == 8'hF0) begin
                p_nxt = P_BREAK;
              end else if (sr[7:0] == 8'hE0) begin
                p_nxt = P_EXT;
              end else if (map_hit) begin
                vv_nxt = 1'b1;
                bv_nxt = map_val;
              end
            end
            P_EXT:   p_nxt = (sr[7:0] == 8'hF0) ? P_BREAK : P_MAKE;
            default: p_nxt = P_MAKE;
          endcase
        end
      end

      default: begin
        rx_nxt = RX_IDLE;
        fe_nxt = 1'b1;
        p_nxt  = P_MAKE;
      end
    endcase
  end

endmodule
